window_feed_11: RTL and testbench

Front-end stage of the 1-D conv layer-11 pipeline. Accepts a serial stream of WIDTH_DATA-bit feature samples plus a small kernel/bias load port, maintains a 5-tap sliding window per frame, and drives the conv stage's five data taps, five kernel taps, bias and `enable` directly. The block is the sole producer of `enable`, so it defines the valid-window cadence for conv → relu → pooling downstream.

---
 rtl/window_feed_11_if.sv | 25 ++
 rtl/window_feed_11.sv | 208 ++++++++++++++++++++
 tb/tb_window_feed_11.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/window_feed_11_if.sv
// window_feed_11_if: sample stream and kernel/bias load bundle for window_feed_11.
//   din/din_valid/din_ready : serial feature samples, transfer = din_valid && din_ready
//   k_wr/k_addr/k_data      : kernel (addr 0..4) and bias (addr 5) write port
// master = producer side (testbench / upstream), slave = window_feed_11.
interface window_feed_11_if #(
  parameter int unsigned WIDTH_DATA   = 16,
  parameter int unsigned WIDTH_KERNEL = 8
);
  logic [WIDTH_DATA-1:0]   din;
  logic                    din_valid;
  logic                    din_ready;
  logic                    k_wr;
  logic [2:0]              k_addr;
  logic [WIDTH_KERNEL-1:0] k_data;

  modport master (
    output din, din_valid, k_wr, k_addr, k_data,
    input  din_ready
  );

  modport slave (
    input  din, din_valid, k_wr, k_addr, k_data,
    output din_ready
  );
endinterface

// File: rtl/window_feed_11.sv
// window_feed_11: front end of the layer-11 1-D conv pipeline. Keeps a 5-tap sliding
// window over each FRAME_LEN-sample frame and drives the conv taps, kernel, bias and
// the registered one-cycle `enable` that paces conv -> relu -> pooling.
//   clk, rst          : clock, synchronous active-high reset
//   bus (slave)       : din/din_valid/din_ready stream, k_wr/k_addr/k_data kernel load
//   data_in1..5       : window taps, 1 = oldest, 5 = newest
//   kernel_in1..5/bias: kernel and bias registers (writable only in IDLE)
//   enable            : taps hold a new complete window
//   frame_done        : coincident with the last enable of a frame
//   k_err             : sticky flag for dropped kernel writes
// Build option: define WINDOW_FEED_PAD_EN for "same" padding (2 leading zeros preloaded,
// 2 trailing zeros shifted in a 2-cycle POST state, FRAME_LEN windows per frame).
module window_feed_11 #(
  parameter int unsigned WIDTH_DATA   = 16,
  parameter int unsigned WIDTH_KERNEL = 8,
  parameter int unsigned FRAME_LEN    = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  window_feed_11_if.slave         bus,
  output logic [WIDTH_DATA-1:0]   data_in1,
  output logic [WIDTH_DATA-1:0]   data_in2,
  output logic [WIDTH_DATA-1:0]   data_in3,
  output logic [WIDTH_DATA-1:0]   data_in4,
  output logic [WIDTH_DATA-1:0]   data_in5,
  output logic [WIDTH_KERNEL-1:0] kernel_in1,
  output logic [WIDTH_KERNEL-1:0] kernel_in2,
  output logic [WIDTH_KERNEL-1:0] kernel_in3,
  output logic [WIDTH_KERNEL-1:0] kernel_in4,
  output logic [WIDTH_KERNEL-1:0] kernel_in5,
  output logic [WIDTH_KERNEL-1:0] bias,
  output logic                    enable,
  output logic                    frame_done,
  output logic                    k_err
);
  localparam int unsigned CntW = $clog2(FRAME_LEN + 1);

`ifdef WINDOW_FEED_PAD_EN
  localparam logic [2:0] FillInit = 3'd2;  // two leading zeros already in the window
`else
  localparam logic [2:0] FillInit = 3'd0;
`endif

  typedef enum logic [1:0] {StIdle, StRun, StPost} state_e;

  state_e                  state_q, state_d;
  logic [WIDTH_DATA-1:0]   win_q [5];
  logic [WIDTH_DATA-1:0]   win_d [5];
  logic [WIDTH_DATA-1:0]   win_base [5];
  logic [WIDTH_KERNEL-1:0] kern_q [5];
  logic [WIDTH_KERNEL-1:0] kern_d [5];
  logic [WIDTH_KERNEL-1:0] bias_q, bias_d;
  logic [2:0]              fill_q, fill_d, fill_base, fill_next;
  logic [CntW-1:0]         in_cnt_q, in_cnt_d, in_cnt_inc;
  logic                    clr_q, clr_d;
  logic                    enable_q, enable_d;
  logic                    frame_done_q, frame_done_d;
  logic                    k_err_q, k_err_d;
  logic                    accept, shift;
  logic [WIDTH_DATA-1:0]   shift_val;
`ifdef WINDOW_FEED_PAD_EN
  logic                    post_q, post_d;
`endif

  always_comb begin
    bus.din_ready = !rst && (state_q != StPost);
  end

  assign accept = bus.din_valid && bus.din_ready;

  always_comb begin
    state_d      = state_q;
    fill_d       = fill_q;
    in_cnt_d     = in_cnt_q;
    clr_d        = 1'b0;
    enable_d     = 1'b0;
    frame_done_d = 1'b0;
    kern_d       = kern_q;
    bias_d       = bias_q;
    k_err_d      = k_err_q;
    shift        = 1'b0;
    shift_val    = bus.din;
`ifdef WINDOW_FEED_PAD_EN
    post_d       = post_q;
`endif

    // The finished frame stays visible during its final enable cycle, then clears here.
    for (int i = 0; i < 5; i++) begin
      win_base[i] = clr_q ? '0 : win_q[i];
    end

    fill_base  = (state_q == StIdle) ? FillInit : fill_q;
    fill_next  = (fill_base == 3'd5) ? 3'd5 : fill_base + 3'd1;
    in_cnt_inc = in_cnt_q + CntW'(1);

    if (accept) begin
      shift    = 1'b1;
      fill_d   = fill_next;
      enable_d = (fill_next == 3'd5);
      in_cnt_d = in_cnt_inc;
      state_d  = StRun;
      if (in_cnt_inc == CntW'(FRAME_LEN)) begin
`ifdef WINDOW_FEED_PAD_EN
        state_d = StPost;
        post_d  = 1'b0;
`else
        frame_done_d = 1'b1;
        state_d      = StIdle;
        in_cnt_d     = '0;
        fill_d       = '0;
        clr_d        = 1'b1;
`endif
      end
    end

`ifdef WINDOW_FEED_PAD_EN
    if (state_q == StPost) begin
      shift     = 1'b1;
      shift_val = '0;
      enable_d  = 1'b1;
      if (post_q) begin
        frame_done_d = 1'b1;
        state_d      = StIdle;
        in_cnt_d     = '0;
        fill_d       = '0;
        clr_d        = 1'b1;
        post_d       = 1'b0;
      end else begin
        post_d = 1'b1;
      end
    end
`endif

    for (int i = 0; i < 5; i++) begin
      win_d[i] = win_base[i];
    end
    if (shift) begin
      for (int i = 0; i < 4; i++) begin
        win_d[i] = win_base[i+1];
      end
      win_d[4] = shift_val;
    end

    // state_q is still IDLE on the edge that accepts a frame's first sample.
    if (bus.k_wr) begin
      if ((state_q == StIdle) && (bus.k_addr <= 3'd5)) begin
        if (bus.k_addr == 3'd5) begin
          bias_d = bus.k_data;
        end else begin
          kern_d[bus.k_addr] = bus.k_data;
        end
      end else begin
        k_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      fill_q       <= '0;
      in_cnt_q     <= '0;
      clr_q        <= 1'b0;
      enable_q     <= 1'b0;
      frame_done_q <= 1'b0;
      bias_q       <= '0;
      k_err_q      <= 1'b0;
      for (int i = 0; i < 5; i++) begin
        win_q[i]  <= '0;
        kern_q[i] <= '0;
      end
`ifdef WINDOW_FEED_PAD_EN
      post_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      fill_q       <= fill_d;
      in_cnt_q     <= in_cnt_d;
      clr_q        <= clr_d;
      enable_q     <= enable_d;
      frame_done_q <= frame_done_d;
      bias_q       <= bias_d;
      k_err_q      <= k_err_d;
      for (int i = 0; i < 5; i++) begin
        win_q[i]  <= win_d[i];
        kern_q[i] <= kern_d[i];
      end
`ifdef WINDOW_FEED_PAD_EN
      post_q       <= post_d;
`endif
    end
  end

  assign data_in1   = win_q[0];
  assign data_in2   = win_q[1];
  assign data_in3   = win_q[2];
  assign data_in4   = win_q[3];
  assign data_in5   = win_q[4];
  assign kernel_in1 = kern_q[0];
  assign kernel_in2 = kern_q[1];
  assign kernel_in3 = kern_q[2];
  assign kernel_in4 = kern_q[3];
  assign kernel_in5 = kern_q[4];
  assign bias       = bias_q;
  assign enable     = enable_q;
  assign frame_done = frame_done_q;
  assign k_err      = k_err_q;
endmodule

// File: tb/tb_window_feed_11.sv
// Scoreboard bench for window_feed_11 with FRAME_LEN = 8. A small window model pushes the
// expected tap vector and frame_done flag per window; a negedge monitor pops on enable.
module tb_window_feed_11;
  localparam int unsigned Fl = 8;
`ifdef WINDOW_FEED_PAD_EN
  localparam bit Pad = 1'b1;
`else
  localparam bit Pad = 1'b0;
`endif

  typedef struct packed {
    logic [79:0] win;
    logic        fd;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] data_in1, data_in2, data_in3, data_in4, data_in5;
  logic [7:0]  kernel_in1, kernel_in2, kernel_in3, kernel_in4, kernel_in5, bias;
  logic        enable, frame_done, k_err;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t q[$];
  logic [15:0] mwin [5];
  int mfill = 0;
  int mcnt  = 0;

  window_feed_11_if #(.WIDTH_DATA(16), .WIDTH_KERNEL(8)) ifc ();

  window_feed_11 #(.WIDTH_DATA(16), .WIDTH_KERNEL(8), .FRAME_LEN(Fl)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (ifc),
    .data_in1   (data_in1),
    .data_in2   (data_in2),
    .data_in3   (data_in3),
    .data_in4   (data_in4),
    .data_in5   (data_in5),
    .kernel_in1 (kernel_in1),
    .kernel_in2 (kernel_in2),
    .kernel_in3 (kernel_in3),
    .kernel_in4 (kernel_in4),
    .kernel_in5 (kernel_in5),
    .bias       (bias),
    .enable     (enable),
    .frame_done (frame_done),
    .k_err      (k_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [79:0] taps();
    return {data_in1, data_in2, data_in3, data_in4, data_in5};
  endfunction

  function automatic logic [79:0] mpack();
    return {mwin[0], mwin[1], mwin[2], mwin[3], mwin[4]};
  endfunction

  task automatic model_shift(input logic [15:0] v);
    for (int i = 0; i < 4; i++) mwin[i] = mwin[i+1];
    mwin[4] = v;
  endtask

  task automatic model_accept(input logic [15:0] v, output bit pushed);
    if (mcnt == 0) begin
      for (int i = 0; i < 5; i++) mwin[i] = '0;
      mfill = Pad ? 2 : 0;
    end
    model_shift(v);
    if (mfill < 5) mfill++;
    mcnt++;
    pushed = (mfill == 5);
    if (pushed) q.push_back('{win: mpack(), fd: (!Pad && mcnt == Fl)});
    if (mcnt == Fl) begin
      if (Pad) begin
        model_shift('0);
        q.push_back('{win: mpack(), fd: 1'b0});
        model_shift('0);
        q.push_back('{win: mpack(), fd: 1'b1});
      end
      mcnt = 0;
    end
  endtask

  // Drive one sample; waits (bounded) for din_ready, then checks enable latency.
  task automatic send(input logic [15:0] v);
    int  guard = 0;
    bit  pushed;
    @(negedge clk);
    ifc.din       = v;
    ifc.din_valid = 1'b1;
    while (!ifc.din_ready && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 10) check_val("ready_timeout", 1, 0);
    model_accept(v, pushed);
    @(posedge clk);
    #1;
    ifc.din_valid = 1'b0;
    check_val("en_latency", enable, pushed);
  endtask

  task automatic kwrite(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    ifc.k_wr   = 1'b1;
    ifc.k_addr = a;
    ifc.k_data = d;
    @(posedge clk);
    #1;
    ifc.k_wr = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while (q.size() != 0 && g < 20) begin
      @(negedge clk);
      g++;
    end
    repeat (2) @(negedge clk);
    check_val("drain", q.size(), 0);
    check_val("taps_clear", taps(), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (enable) begin
      if (q.size() == 0) begin
        check_val("enable_unexp", 1, 0);
      end else begin
        e = q.pop_front();
        check_val("window", taps(), e.win);
        check_val("frame_done", frame_done, e.fd);
      end
    end else if (frame_done) begin
      check_val("fd_stray", 1, 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ifc.din       = '0;
    ifc.din_valid = 1'b0;
    ifc.k_wr      = 1'b0;
    ifc.k_addr    = '0;
    ifc.k_data    = '0;
    for (int i = 0; i < 5; i++) mwin[i] = '0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_taps", taps(), 0);
    check_val("rst_kern", {kernel_in1, kernel_in2, kernel_in3, kernel_in4, kernel_in5, bias}, 0);
    check_val("rst_flags", {enable, frame_done, k_err}, 0);
    check_val("rst_ready", ifc.din_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("ready_idle", ifc.din_ready, 1);

    // Kernel/bias load in IDLE
    kwrite(3'd0, 8'd3);
    kwrite(3'd1, 8'hFF);
    kwrite(3'd2, 8'd2);
    kwrite(3'd3, 8'd0);
    kwrite(3'd4, 8'd5);
    kwrite(3'd5, 8'd7);
    check_val("kern_load", {kernel_in1, kernel_in2, kernel_in3, kernel_in4, kernel_in5},
              {8'd3, 8'hFF, 8'd2, 8'd0, 8'd5});
    check_val("bias_load", bias, 8'd7);
    check_val("kerr_clean", k_err, 0);

    // Frame A: 1..8 back to back
    for (int i = 1; i <= 8; i++) send(16'(i));
    if (Pad) begin
      check_val("post_ready0", ifc.din_ready, 0);
      @(posedge clk);
      #1;
      check_val("post_ready1", ifc.din_ready, 0);
      @(posedge clk);
      #1;
      check_val("post_ready2", ifc.din_ready, 1);
    end
    drain();

    // Frame B: alternating gaps, plus a kernel write while running
    for (int i = 11; i <= 18; i++) begin
      send(16'(i));
      if (i == 12) begin
        kwrite(3'd0, 8'h55);
        check_val("kerr_run", k_err, 1);
        check_val("kern_run_hold", kernel_in1, 8'd3);
      end else begin
        @(posedge clk);
        #1;
        if (i < 16) check_val("gap_enable", enable, 0);
      end
    end
    drain();

    // Illegal address in IDLE
    kwrite(3'd6, 8'hAA);
    check_val("kerr_addr", k_err, 1);
    check_val("kern_addr_hold", {kernel_in1, kernel_in2, kernel_in3, kernel_in4, kernel_in5, bias},
              {8'd3, 8'hFF, 8'd2, 8'd0, 8'd5, 8'd7});

    // Frame C: reset after 6 samples
    for (int i = 21; i <= 26; i++) send(16'(i));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_val("mid_rst_taps", taps(), 0);
    check_val("mid_rst_flags", {enable, frame_done, k_err, ifc.din_ready}, 0);
    check_val("mid_rst_kern", {kernel_in1, kernel_in2, kernel_in3, kernel_in4, kernel_in5, bias}, 0);
    @(negedge clk);
    rst = 1'b0;
    mcnt = 0;
    q.delete();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_val("post_rst_quiet", {enable, frame_done}, 0);
    end

    // Frame D: first sample coincides with a bias write in IDLE
    @(negedge clk);
    ifc.k_wr   = 1'b1;
    ifc.k_addr = 3'd5;
    ifc.k_data = 8'd9;
    send(16'd31);
    ifc.k_wr = 1'b0;
    check_val("bias_first_sample", bias, 8'd9);
    for (int i = 32; i <= 38; i++) send(16'(i));
    drain();
    check_val("kerr_final", k_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
